// File: rtl/cpu_sequencer.sv
// CPU clock-enable divider, reset/run/pause/step sequencer and IRQ synchronizer/filter for RangerRisc.
// Optional feature: define SEQ_STEP_EN to honour run_i/step_i (SHALT/SSTEP states).
module cpu_sequencer #(
  parameter int unsigned DIV_N       = 14,
  parameter int unsigned RESET_TICKS = 4,
  parameter int unsigned IRQ_FILTER  = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sw_reset_i,
  input  logic       run_i,
  input  logic       step_i,
  input  logic       irq_ni,
  output logic       cpu_ce_o,
  output logic       cpu_reset_no,
  output logic       irq_no,
  output logic       halted_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_STEP  = 2'd3
  } state_e;

  localparam int unsigned DW = DIV_N + 1;

  logic [DW-1:0] div_q, div_d;
  logic          tick;
  state_e        state_q, state_d;
  logic [7:0]    rcnt_q, rcnt_d;
  logic          ce_q, ce_d;
  logic          rst_n_q, rst_n_d;
  logic [1:0]    sync_q;
  logic          irq_q, irq_d;
  logic [3:0]    fcnt_q, fcnt_d;

  assign tick = &div_q;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    div_d   = div_q + DW'(1);
    state_d = state_q;
    rcnt_d  = rcnt_q;
    ce_d    = tick && (state_q != S_HALT);

    case (state_q)
      S_RESET: begin
        if (tick) begin
          if (rcnt_q == 8'(RESET_TICKS - 1)) begin
            rcnt_d = '0;
`ifdef SEQ_STEP_EN
            state_d = run_i ? S_RUN : S_HALT;
`else
            state_d = S_RUN;
`endif
          end else begin
            rcnt_d = rcnt_q + 8'd1;
          end
        end
      end
`ifdef SEQ_STEP_EN
      S_RUN:  if (tick && !run_i) state_d = S_HALT;
      S_HALT: begin
        if (run_i)       state_d = S_RUN;
        else if (step_i) state_d = S_STEP;
      end
      S_STEP: if (tick) state_d = S_HALT;
`endif
      default: ;
    endcase

    if (sw_reset_i) begin
      state_d = S_RESET;
      rcnt_d  = '0;
      div_d   = '0;
    end

    // Core reset follows the next state so it lifts together with the last reset tick's enable.
    rst_n_d = (state_d != S_RESET);
  end

  // A sample must disagree with irq_no for IRQ_FILTER consecutive clks before irq_no follows it.
  always_comb begin
    irq_d  = irq_q;
    fcnt_d = '0;
    if (sync_q[1] != irq_q) begin
      if (({1'b0, fcnt_q} + 5'd1) >= 5'(IRQ_FILTER)) irq_d = sync_q[1];
      else                                           fcnt_d = fcnt_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the synchronizer resets to idle (1).
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      div_q   <= '0;
      state_q <= S_RESET;
      rcnt_q  <= '0;
      ce_q    <= 1'b0;
      rst_n_q <= 1'b0;
      sync_q  <= 2'b11;
      irq_q   <= 1'b1;
      fcnt_q  <= '0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      ce_q    <= ce_d;
      rst_n_q <= rst_n_d;
      sync_q  <= {sync_q[0], irq_ni};
      irq_q   <= irq_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign cpu_ce_o     = ce_q;
  assign cpu_reset_no = rst_n_q;
  assign irq_no       = irq_q;
  assign state_o      = state_q;

`ifdef SEQ_STEP_EN
  assign halted_o = (state_q == S_HALT);
`else
  // Pause/step controls have no effect in this build.
  logic unused_ctrl;
  assign unused_ctrl = run_i ^ step_i;
  assign halted_o    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized and directed bench for cpu_sequencer against a cycle-count reference model.
// Expectations adapt to whether SEQ_STEP_EN is defined.
module tb_cpu_sequencer;
  localparam int DIV_N       = 1;
  localparam int RESET_TICKS = 2;
  localparam int IRQ_FILTER  = 3;
  localparam int PERIOD      = 4;
`ifdef SEQ_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  localparam int M_RESET = 0, M_RUN = 1, M_HALT = 2, M_STEP = 3;

  logic       clk = 1'b0;
  logic       reset_i, sw_reset_i, run_i, step_i, irq_ni;
  logic       cpu_ce_o, cpu_reset_no, irq_no, halted_o;
  logic [1:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time since divider clear, reset ticks seen, abstract mode, IRQ sample history.
  int m_cyc, m_ticks, m_state;
  bit m_ce, m_irq;
  bit sync_pipe[$];
  bit hist[$];

  cpu_sequencer #(.DIV_N(DIV_N), .RESET_TICKS(RESET_TICKS), .IRQ_FILTER(IRQ_FILTER)) dut (
    .clk_i(clk), .reset_i(reset_i), .sw_reset_i(sw_reset_i), .run_i(run_i), .step_i(step_i),
    .irq_ni(irq_ni), .cpu_ce_o(cpu_ce_o), .cpu_reset_no(cpu_reset_no), .irq_no(irq_no),
    .halted_o(halted_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_ticks = 0; m_state = M_RESET; m_ce = 1'b0; m_irq = 1'b1;
    sync_pipe = {1'b1, 1'b1};
    hist = {};
  endtask

  task automatic model_edge();
    bit tick, s, same;
    tick = (m_cyc % PERIOD) == PERIOD - 1;
    m_ce = tick && (m_state != M_HALT);
    if (sw_reset_i) begin
      m_state = M_RESET; m_ticks = 0; m_cyc = 0;
    end else begin
      m_cyc++;
      case (m_state)
        M_RESET: if (tick) begin
          m_ticks++;
          if (m_ticks == RESET_TICKS) m_state = (!STEP_EN || run_i) ? M_RUN : M_HALT;
        end
        M_RUN:  if (STEP_EN && tick && !run_i) m_state = M_HALT;
        M_HALT: if (run_i) m_state = M_RUN; else if (step_i) m_state = M_STEP;
        M_STEP: if (tick) m_state = M_HALT;
        default: ;
      endcase
    end
    s = sync_pipe.pop_front();
    sync_pipe.push_back(irq_ni);
    hist.push_back(s);
    if (hist.size() > IRQ_FILTER) void'(hist.pop_front());
    if (hist.size() == IRQ_FILTER && s != m_irq) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != s) same = 1'b0;
      if (same) m_irq = s;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ce",     cpu_ce_o,     m_ce);
    check("rst_n",  cpu_reset_no, m_state != M_RESET);
    check("irq",    irq_no,       m_irq);
    check("halted", halted_o,     m_state == M_HALT);
    check("state",  state_o,      m_state);
  endtask

  initial begin
    int cnt;
    reset_i = 1'b0; sw_reset_i = 1'b0; run_i = 1'b1; step_i = 1'b0; irq_ni = 1'b1;
    model_reset();
    #23;
    check("rst_ce", cpu_ce_o, 0);
    check("rst_rst_n", cpu_reset_no, 0);
    check("rst_irq", irq_no, 1);
    check("rst_halted", halted_o, 0);
    check("rst_state", state_o, 0);

    // Power-up
    @(negedge clk) reset_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      check("pu_ce", cpu_ce_o, (c % 4) == 0);
      check("pu_rst_n", cpu_reset_no, c >= 8);
      check("pu_state", state_o, (c >= 8) ? 1 : 0);
    end

    // Pause
    run_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin cycle(); cnt += int'(cpu_ce_o); end
    check("pause_ce_count", cnt, STEP_EN ? 1 : 6);
    check("pause_halted", halted_o, STEP_EN);
    check("pause_state", state_o, STEP_EN ? 2 : 1);

    // Single step with a redundant second request
    cnt = 0;
    step_i = 1'b1; cycle(); cnt += int'(cpu_ce_o);
    step_i = 1'b1; cycle(); cnt += int'(cpu_ce_o);
    step_i = 1'b0;
    for (int i = 0; i < 14; i++) begin cycle(); cnt += int'(cpu_ce_o); end
    check("step_ce_count", cnt, STEP_EN ? 1 : 4);
    check("step_state", state_o, STEP_EN ? 2 : 1);

    // Software reset coinciding with step
    sw_reset_i = 1'b1; step_i = 1'b1;
    cycle();
    sw_reset_i = 1'b0; step_i = 1'b0;
    check("sw_state", state_o, 0);
    check("sw_rst_n", cpu_reset_no, 0);
    cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      cnt += int'(cpu_ce_o);
      if (c == 7) check("sw_state_c7", state_o, 0);
      if (c == 8) begin
        check("sw_state_c8", state_o, STEP_EN ? 2 : 1);
        check("sw_rst_n_c8", cpu_reset_no, 1);
      end
    end
    check("sw_ce_count", cnt, STEP_EN ? 2 : 3);

    // IRQ glitch, then a long low pulse
    cnt = 0;
    irq_ni = 1'b0; cycle(); cnt += int'(!irq_no);
    cycle(); cnt += int'(!irq_no);
    irq_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin cycle(); cnt += int'(!irq_no); end
    check("irq_glitch_lows", cnt, 0);
    irq_ni = 1'b0;
    for (int c = 1; c <= 10; c++) begin cycle(); check("irq_fall", irq_no, c < 5); end
    irq_ni = 1'b1;
    for (int c = 1; c <= 10; c++) begin cycle(); check("irq_rise", irq_no, c >= 5); end

    // Randomized operation
    run_i = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) run_i = ~run_i;
      step_i     = ($urandom_range(0, 5) == 0);
      sw_reset_i = ($urandom_range(0, 90) == 0);
      if ($urandom_range(0, 3) == 0) irq_ni = ~irq_ni;
      cycle();
    end

    // Async reset during SSTEP with irq_no asserted
    run_i = 1'b0; step_i = 1'b0; sw_reset_i = 1'b0; irq_ni = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    for (int i = 0; i < 40 && !halted_o; i++) cycle();
`ifdef SEQ_STEP_EN
    check("halt_wait", halted_o, 1);
    step_i = 1'b1; cycle(); step_i = 1'b0;
    check("ar_pre_state", state_o, 3);
`endif
    check("ar_pre_irq", irq_no, 0);
    @(posedge clk);
    #2 reset_i = 1'b0;
    #1;
    check("ar_ce", cpu_ce_o, 0);
    check("ar_rst_n", cpu_reset_no, 0);
    check("ar_irq", irq_no, 1);
    check("ar_halted", halted_o, 0);
    check("ar_state", state_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ar_hold_ce", cpu_ce_o, 0);
    end
    model_reset();
    irq_ni = 1'b1; run_i = 1'b1;
    reset_i = 1'b1;
    for (int i = 0; i < 16; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
